sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO. Successor to the fixed 8x16 FIFO, with configurable width and depth.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_ram_dp.sv | 39 +++
 rtl/sync_fifo_flags.sv | 99 +++++++++
 tb/tb_sync_fifo_flags.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised FIFO.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_AE_LEVEL   = 2;

    // Number of words addressed by a pointer of the given width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointer width must give between 4 and 1024 words.
    function automatic bit addr_width_ok(input int addr_width);
        return (addr_width >= 2) && (addr_width <= 10);
    endfunction

    // almost_full threshold must be reachable and non-trivial.
    function automatic bit af_level_ok(input int af_level, input int depth);
        return (af_level >= 1) && (af_level <= depth);
    endfunction

    // almost_empty threshold must leave the full state outside it.
    function automatic bit ae_level_ok(input int ae_level, input int depth);
        return (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module fifo_ram_dp
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array; contents deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register: captures the old word on a same-address collision and
    // holds its value whenever no read is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with protected pointers, occupancy count, programmable
// almost-full/almost-empty flags and registered overflow/underflow pulses.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = ADDR_WIDTH + 1;

    // Reject illegal parameter sets at elaboration.
    if (!addr_width_ok(ADDR_WIDTH)) begin : g_bad_addr_width
        $error("sync_fifo_flags: ADDR_WIDTH must be in 2..10");
    end
    if (!af_level_ok(AF_LEVEL, DEPTH)) begin : g_bad_af_level
        $error("sync_fifo_flags: AF_LEVEL must be in 1..DEPTH");
    end
    if (!ae_level_ok(AE_LEVEL, DEPTH)) begin : g_bad_ae_level
        $error("sync_fifo_flags: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // Requests are only honoured when they cannot corrupt the pointers.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Flags decode from the registered count, so they move only after an edge.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // Occupancy change: +1 per accepted write, -1 per accepted read.
    always_comb begin
        count_next = count + CW'(wr_acc) - CW'(rd_acc);
    end

    // Pointer, count, read-valid and error-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count     <= count_next;
            rd_valid  <= rd_acc;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    fifo_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: the driver keeps a queue-based model
// of the FIFO and pushes expected read words; a negedge monitor compares.
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_rd  [$];
    bit            exp_valid = 1'b0;
    bit            exp_ov    = 1'b0;
    bit            exp_uf    = 1'b0;
    logic [DW-1:0] last_rd   = '0;

    sync_fifo_flags #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model advances on the pre-edge occupancy.
    task automatic cycle(input bit we, input logic [DW-1:0] wd, input bit re);
        int sz;
        bit w_ok;
        bit r_ok;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        sz     = model_q.size();
        w_ok   = we && (sz < DEPTH);
        r_ok   = re && (sz > 0);
        exp_ov = we && (sz == DEPTH);
        exp_uf = re && (sz == 0);
        exp_valid = r_ok;
        if (r_ok) begin
            last_rd = model_q.pop_front();
            exp_rd.push_back(last_rd);
        end
        if (w_ok) model_q.push_back(wd);
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_q.delete();
        exp_rd.delete();
        exp_valid = 1'b0;
        exp_ov    = 1'b0;
        exp_uf    = 1'b0;
        last_rd   = '0;
        #1;
        chk("rst_async_count", count, 0);
        chk("rst_async_empty", empty, 1);
        chk("rst_async_rd_valid", rd_valid, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: flags against the model, read words against the scoreboard.
    always @(negedge clk) begin
        chk("count", count, model_q.size());
        chk("empty", empty, model_q.size() == 0);
        chk("full", full, model_q.size() == DEPTH);
        chk("almost_full", almost_full, model_q.size() >= AF);
        chk("almost_empty", almost_empty, model_q.size() <= AE);
        chk("rd_valid", rd_valid, exp_valid);
        chk("overflow", overflow, exp_ov);
        chk("underflow", underflow, exp_uf);
        if (rd_valid) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else                    chk("rd_data", rd_data, exp_rd.pop_front());
        end else begin
            chk("rd_hold", rd_data, last_rd);
        end
    end

    initial begin
        int pw;
        int pr;

        // 1: reset then idle
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        chk("t1_rd_data", rd_data, 0);
        $display("test1 reset/idle done checks=%0d", checks);

        // 2: fill with 0x00..0x0F, then one overflowing write
        for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i), 0);
        chk("t2_full", full, 1);
        cycle(1, 8'hEE, 0);
        cycle(0, '0, 0);
        chk("t2_count", count, 16);
        $display("test2 fill/overflow done checks=%0d", checks);

        // 3: drain in order, then one underflowing read
        for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1);
        cycle(0, '0, 1);
        cycle(0, '0, 0);
        chk("t3_hold", rd_data, 8'h0F);
        $display("test3 drain/underflow done checks=%0d", checks);

        // 4: preload 5, then 40 cycles of simultaneous read/write across the wrap
        for (int i = 0; i < 5; i++) cycle(1, DW'($urandom), 0);
        for (int i = 0; i < 40; i++) cycle(1, DW'($urandom), 1);
        cycle(0, '0, 0);
        chk("t4_count", count, 5);
        while (model_q.size() > 0) cycle(0, '0, 1);
        $display("test4 streaming done checks=%0d", checks);

        // 5: simultaneous requests at the full and empty boundaries
        while (model_q.size() < DEPTH) cycle(1, DW'($urandom), 0);
        cycle(1, DW'($urandom), 1);
        chk("t5_count_from_full", count, 15);
        while (model_q.size() > 0) cycle(0, '0, 1);
        cycle(1, DW'($urandom), 1);
        chk("t5_count_from_empty", count, 1);
        cycle(0, '0, 1);
        $display("test5 boundary collisions done checks=%0d", checks);

        // Random traffic with drifting write/read bias to visit every flag region
        for (int ph = 0; ph < 8; ph++) begin
            pw = (ph % 2 == 0) ? 80 : 25;
            pr = (ph % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 50; i++) begin
                cycle($urandom_range(99) < pw, DW'($urandom), $urandom_range(99) < pr);
            end
        end
        $display("random phase done checks=%0d", checks);

        // 6: reset with contents, then a fresh write/read
        for (int i = 0; i < 7; i++) cycle(1, DW'($urandom), 0);
        reset_mid();
        cycle(1, 8'hA5, 0);
        cycle(0, '0, 1);
        chk("t6_rd_data", rd_data, 8'hA5);
        cycle(0, '0, 0);
        $display("test6 mid-reset done checks=%0d", checks);

        chk("sb_leftover", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
